// File: rtl/branch_stats_counter.sv
// Branch statistics for the SweRV core: live retired/taken/mispredict counters
// with periodic and on-demand snapshots; clear and freeze arrive from switches.

module branch_stats_counter #(
   parameter int CNT_W       = 32,
   parameter int SNAP_PERIOD = 50_000_000,
   parameter bit SAT         = 1'b1
) (
   input  logic             clk_core,
   input  logic             rstn,
   input  logic             i_br_valid,
   input  logic             i_br_taken,
   input  logic             i_br_mispred,
   input  logic             i_clear,
   input  logic             i_freeze,
   input  logic             i_snap_req,
   output logic [CNT_W-1:0] o_branches,
   output logic [CNT_W-1:0] o_taken,
   output logic [CNT_W-1:0] o_mispred,
   output logic             o_snap_valid,
   output logic             o_overflow
);

   localparam int               PW         = (SNAP_PERIOD > 2) ? $clog2(SNAP_PERIOD) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(SNAP_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FROZEN = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   state_t           state;
   logic             clr_meta;
   logic             clr_s;
   logic             clr_d;
   logic             frz_meta;
   logic             frz_s;
   logic             clr_rise;
   logic [PW-1:0]    presc;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] tk_cnt;
   logic [CNT_W-1:0] mp_cnt;
   logic             ev_br;
   logic             ev_tk;
   logic             ev_mp;
   logic             limit_hit;
   logic             auto_snap;
   logic             snap_trig;

   // An event on an all-ones counter either pins it there or wraps it to zero.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic ev);
      logic [CNT_W-1:0] r;
      r = v;
      if (ev) begin
         if (v == CNT_MAX) begin
            r = SAT ? CNT_MAX : '0;
         end else begin
            r = v + CNT_W'(1);
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         clr_meta <= 1'b0;
         clr_s    <= 1'b0;
         clr_d    <= 1'b0;
         frz_meta <= 1'b0;
         frz_s    <= 1'b0;
      end else begin
         clr_meta <= i_clear;
         clr_s    <= clr_meta;
         clr_d    <= clr_s;
         frz_meta <= i_freeze;
         frz_s    <= frz_meta;
      end
   end

   assign clr_rise = clr_s & ~clr_d;

   always_comb begin
      ev_br     = i_br_valid;
      ev_tk     = i_br_valid & i_br_taken;
      ev_mp     = i_br_valid & i_br_mispred;
      limit_hit = (ev_br && (br_cnt == CNT_MAX)) ||
                  (ev_tk && (tk_cnt == CNT_MAX)) ||
                  (ev_mp && (mp_cnt == CNT_MAX));
      auto_snap = (state == RUN) && (presc == PRESC_LAST);
      snap_trig = auto_snap || (i_snap_req && (state != CLEAR));
   end

   // A clear edge wins over everything; snapshots copy the pre-increment values.
   always_ff @(posedge clk_core or negedge rstn) begin
      if (!rstn) begin
         state        <= RUN;
         presc        <= '0;
         br_cnt       <= '0;
         tk_cnt       <= '0;
         mp_cnt       <= '0;
         o_branches   <= '0;
         o_taken      <= '0;
         o_mispred    <= '0;
         o_snap_valid <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         o_snap_valid <= 1'b0;
         if (clr_rise) begin
            state      <= CLEAR;
            presc      <= '0;
            br_cnt     <= '0;
            tk_cnt     <= '0;
            mp_cnt     <= '0;
            o_branches <= '0;
            o_taken    <= '0;
            o_mispred  <= '0;
            o_overflow <= 1'b0;
         end else begin
            if (snap_trig) begin
               o_branches   <= br_cnt;
               o_taken      <= tk_cnt;
               o_mispred    <= mp_cnt;
               o_snap_valid <= 1'b1;
            end
            case (state)
               RUN: begin
                  br_cnt <= bump(br_cnt, ev_br);
                  tk_cnt <= bump(tk_cnt, ev_tk);
                  mp_cnt <= bump(mp_cnt, ev_mp);
                  if (limit_hit) begin
                     o_overflow <= 1'b1;
                  end
                  presc <= auto_snap ? '0 : presc + PW'(1);
                  state <= frz_s ? FROZEN : RUN;
               end
               FROZEN: state <= frz_s ? FROZEN : RUN;
               CLEAR:  state <= frz_s ? FROZEN : RUN;
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule
